// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
//
// Receive-only PS/2 mouse front end. Synchronizes the raw PS/2 clock and
// data lines, deframes 11-bit device-to-host frames, assembles standard
// 3-byte movement packets and integrates the signed deltas into an absolute
// pointer position clamped to the screen.
//
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   ps2_clk      - raw PS/2 clock from the device (asynchronous to clk)
//   ps2_data     - raw PS/2 data from the device (asynchronous to clk)
//   mouseX       - pointer X, 0..X_MAX
//   mouseY       - pointer Y, 0..Y_MAX, 0 at the top of the screen
//   mouseBotton  - left button level from the last accepted packet
//   packet_valid - one-cycle pulse when a packet updates the outputs
//   frame_err    - one-cycle pulse when a frame or packet is discarded
//
// Configuration macro:
//   PS2_PARITY_CHECK_EN - when defined, frames whose data bits plus parity
//                         bit do not hold an odd number of ones are rejected.
//                         When undefined the parity bit is sampled and ignored.

module ps2_mouse_tracker #(
    parameter int SYNC_STAGES    = 2,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479,
    parameter int X_INIT         = 320,
    parameter int Y_INIT         = 240,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouseX,
    output logic [9:0] mouseY,
    output logic       mouseBotton,
    output logic       packet_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    // Line synchronizers and falling-edge detector. Idle PS/2 lines are high,
    // so the flops reset to 1 to avoid a spurious edge after reset.
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    // Frame deframer state
    frame_state_t     state, state_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       shift_reg, shift_d;
    logic             parity_bit, parity_d;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_d;
    logic             byte_valid;
    logic             frame_bad;
    logic             parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    assign parity_ok = ^{shift_reg, parity_bit};
`else
    // The parity bit is still captured but never rejects a frame.
    assign parity_ok = parity_bit | 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            shift_reg  <= shift_d;
            parity_bit <= parity_d;
            idle_cnt   <= idle_cnt_d;
        end
    end

    // Next-state logic. The idle counter only runs while a frame is in
    // progress; an edge in the same cycle as the timeout wins and clears it.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift_reg;
        parity_d   = parity_bit;
        idle_cnt_d = '0;
        byte_valid = 1'b0;
        frame_bad  = 1'b0;

        if (state != IDLE && !fall) begin
            idle_cnt_d = idle_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (fall && !data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s, shift_reg[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (data_s && parity_ok) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state != IDLE && !fall && idle_cnt == TIMEOUT_VAL) begin
            state_d    = IDLE;
            idle_cnt_d = '0;
            frame_bad  = 1'b1;
        end
    end

    // Packet assembly registers
    logic [1:0] pkt_idx;
    logic       b0_left;
    logic       b0_xsign;
    logic       b0_ysign;
    logic       b0_xovf;
    logic       b0_yovf;
    logic [7:0] b1_dx;

    // Position integration. Byte 2 (dy) is taken straight from the shift
    // register in the cycle it becomes valid. All arithmetic is 12-bit
    // signed so the sum can go negative or past the limit before clamping.
    logic signed [11:0] dx, dy, x_sum, y_sum;
    logic        [9:0]  x_next, y_next;

    always_comb begin
        dx = b0_xovf ? 12'sd0 : $signed({{3{b0_xsign}}, b0_xsign, b1_dx});
        dy = b0_yovf ? 12'sd0 : $signed({{3{b0_ysign}}, b0_ysign, shift_reg});
        x_sum = $signed({2'b00, mouseX}) + dx;
        y_sum = $signed({2'b00, mouseY}) - dy;

        if (x_sum < 12'sd0) begin
            x_next = '0;
        end else if (x_sum > X_MAX_S) begin
            x_next = 10'(X_MAX);
        end else begin
            x_next = x_sum[9:0];
        end

        if (y_sum < 12'sd0) begin
            y_next = '0;
        end else if (y_sum > Y_MAX_S) begin
            y_next = 10'(Y_MAX);
        end else begin
            y_next = y_sum[9:0];
        end
    end

    // Byte sequencing. A first byte without bit3 set cannot be a packet
    // header, so it is dropped silently to resynchronize on the next byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_idx      <= '0;
            b0_left      <= 1'b0;
            b0_xsign     <= 1'b0;
            b0_ysign     <= 1'b0;
            b0_xovf      <= 1'b0;
            b0_yovf      <= 1'b0;
            b1_dx        <= '0;
            mouseX       <= 10'(X_INIT);
            mouseY       <= 10'(Y_INIT);
            mouseBotton  <= 1'b0;
            packet_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            frame_err    <= frame_bad;
            if (frame_bad) begin
                pkt_idx <= '0;
            end else if (byte_valid) begin
                case (pkt_idx)
                    2'd0: begin
                        if (shift_reg[3]) begin
                            b0_left  <= shift_reg[0];
                            b0_xsign <= shift_reg[4];
                            b0_ysign <= shift_reg[5];
                            b0_xovf  <= shift_reg[6];
                            b0_yovf  <= shift_reg[7];
                            pkt_idx  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        b1_dx   <= shift_reg;
                        pkt_idx <= 2'd2;
                    end
                    2'd2: begin
                        mouseX       <= x_next;
                        mouseY       <= y_next;
                        mouseBotton  <= b0_left;
                        packet_valid <= 1'b1;
                        pkt_idx      <= 2'd0;
                    end
                    default: pkt_idx <= 2'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker
//
// Self-checking bench for ps2_mouse_tracker. Drives PS/2 frames on the raw
// lines, pushes the expected pointer state for every packet into a queue,
// and pops/compares it whenever the DUT pulses packet_valid. Pulse counts
// of packet_valid and frame_err are compared against expected totals at
// checkpoints. A shortened TIMEOUT_CYCLES keeps the timeout case short.

module tb_ps2_mouse_tracker;

    localparam int TIMEOUT = 3000;
    localparam int HALF    = 10;

    typedef struct {
        int x;
        int y;
        int btn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] mouseX;
    logic [9:0] mouseY;
    logic       mouseBotton;
    logic       packet_valid;
    logic       frame_err;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   pv_cnt = 0;
    int   err_cnt = 0;
    int   exp_pv = 0;
    int   exp_err = 0;
    int   exp_x, exp_y, exp_btn;

    ps2_mouse_tracker #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .mouseX      (mouseX),
        .mouseY      (mouseY),
        .mouseBotton (mouseBotton),
        .packet_valid(packet_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every packet_valid pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (frame_err === 1'b1) err_cnt++;
            if (packet_valid === 1'b1) begin
                pv_cnt++;
                checkOutput("sb_has_entry", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    checkOutput("pkt_x", int'(mouseX), e.x);
                    checkOutput("pkt_y", int'(mouseY), e.y);
                    checkOutput("pkt_btn", int'(mouseBotton), e.btn);
                end
            end
        end
    end

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference model of one accepted packet; pushes the expected result
    task automatic modelPacket(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int   dx, dy;
        exp_t e;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        exp_x   = clampInt(exp_x + dx, 0, 639);
        exp_y   = clampInt(exp_y - dy, 0, 479);
        exp_btn = int'(b0[0]);
        e.x = exp_x;
        e.y = exp_y;
        e.btn = exp_btn;
        sb_q.push_back(e);
        exp_pv++;
    endtask

    task automatic ps2Bit(input logic v);
        ps2_data = v;
        waitCycles(HALF);
        ps2_clk = 1'b0;
        waitCycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input bit bad_par);
        logic        p;
        logic [10:0] bits;
        p = ~^b;
        if (bad_par) p = ~p;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2Bit(bits[i]);
        end
        waitCycles(30);
    endtask

    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        modelPacket(b0, b1, b2);
        sendFrame(b0, 1'b0);
        sendFrame(b1, 1'b0);
        sendFrame(b2, 1'b0);
    endtask

    task automatic doReset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b0;
        waitCycles(5);
        rst_n    = 1'b1;
        exp_x    = 320;
        exp_y    = 240;
        exp_btn  = 0;
        sb_q.delete();
        waitCycles(5);
    endtask

    // Steady-state check: outputs hold the model state, no pending packets
    task automatic checkpoint(input string tag);
        checkOutput({tag, "_pending"}, sb_q.size(), 0);
        checkOutput({tag, "_pv_count"}, pv_cnt, exp_pv);
        checkOutput({tag, "_err_count"}, err_cnt, exp_err);
        checkOutput({tag, "_x"}, int'(mouseX), exp_x);
        checkOutput({tag, "_y"}, int'(mouseY), exp_y);
        checkOutput({tag, "_btn"}, int'(mouseBotton), exp_btn);
    endtask

    initial begin
        // Reset with idle lines: no pulses for 1000 cycles
        doReset();
        waitCycles(1000);
        checkpoint("reset");

        // Basic packet with left button
        applyStimulus(8'h09, 8'h0A, 8'h05);
        checkpoint("basic");
        checkOutput("basic_x_const", int'(mouseX), 330);
        checkOutput("basic_y_const", int'(mouseY), 235);

        // Negative X / negative Y deltas with clamping at both edges
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h38, 8'h80, 8'h80);
            checkpoint("clamp");
        end
        checkOutput("clamp_x_const", int'(mouseX), 0);
        checkOutput("clamp_y_const", int'(mouseY), 479);

        // Bad parity on a header byte
        doReset();
`ifdef PS2_PARITY_CHECK_EN
        sendFrame(8'h09, 1'b1);
        exp_err++;
        checkpoint("parity_err");
        applyStimulus(8'h08, 8'h01, 8'h01);
        checkpoint("parity_recover");
`else
        modelPacket(8'h09, 8'h01, 8'h01);
        sendFrame(8'h09, 1'b1);
        sendFrame(8'h01, 1'b0);
        sendFrame(8'h01, 1'b0);
        checkpoint("parity_ignored");
`endif

        // Timeout mid-frame: start bit plus four data bits, then silence
        doReset();
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b1);
        ps2_data = 1'b1;
        waitCycles(TIMEOUT + 5);
        exp_err++;
        checkpoint("timeout");
        applyStimulus(8'h08, 8'h02, 8'h00);
        checkpoint("timeout_recover");
        checkOutput("timeout_x_const", int'(mouseX), 322);

        // Header resync: 0x00 is dropped silently
        doReset();
        sendFrame(8'h00, 1'b0);
        checkpoint("resync_drop");
        applyStimulus(8'h08, 8'h01, 8'h01);
        checkpoint("resync");

        // X overflow: X delta ignored, Y still applied
        applyStimulus(8'h48, 8'hFF, 8'h01);
        checkpoint("xovf");
        checkOutput("xovf_x_const", int'(mouseX), 321);
        checkOutput("xovf_y_const", int'(mouseY), 238);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
